input_frontend: RTL and testbench
=================================

# input_frontend

Parametrised successor to the processor's front-panel input stage. It debounces NKEYS push-buttons with per-key counter state machines and emits a clean level and a one-cycle press pulse per key. It captures the switch word into a holding register on a designated key press and drives the tri-state-free data bus only while external input is enabled. It sits between the board switches/keys and the processor's bus and control unit.

## Interface
- WIDTH, 10, width of RawData, databus and the holding register
- NKEYS, 2, number of debounced keys (key 0 = clock key, key 1 = peek key by convention)
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a level change (10 ms at 50 MHz); legal range ≥ 2
- LATCH_KEY, 1, index of the key whose press pulse loads RawData into the holding register; must be < NKEYS
- CLK50M  input  1  system clock, 50 MHz
- Reset  input  1  synchronous, active-high reset
- RawData  input  WIDTH  switch word, asynchronous to CLK50M
- RawKeys  input  NKEYS  raw key levels, active-high, asynchronous
- Extrn_Enable  input  1  when 1, holding register drives databus
- KeyLevel  output  NKEYS  debounced key levels
- KeyPulse  output  NKEYS  one-cycle pulse on each accepted press (0→1)
- databus  output  WIDTH  holding register when Extrn_Enable=1, else all zeros
- data2bit  output  2  holding register bits [1:0]
- DataValid  output  1  one-cycle pulse in the cycle after the holding register loads

## Operation
- One clock; Reset is synchronous and active-high. All state updates on rising CLK50M.
- Per key, an independent 4-state FSM with counter cnt, width $clog2(DEBOUNCE_CYCLES+1):
  - IDLE (level 0): sample=1 → PRESS_CHK, cnt=1; else stay, cnt=0.
  - PRESS_CHK: sample=0 → IDLE, cnt=0; sample=1 and cnt==DEBOUNCE_CYCLES-1 → HELD, level←1, pulse←1; else cnt+1.
  - HELD (level 1): sample=0 → REL_CHK, cnt=1; else stay.
  - REL_CHK: sample=1 → HELD, cnt=0; sample=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE, level←0 (no pulse); else cnt+1.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- KeyPulse[i] is registered, high exactly one cycle per accepted press, regardless of hold time.
- Holding register: on the cycle KeyPulse[LATCH_KEY]=1, loads the current sampled RawData; DataValid=1 on the following cycle only.
- Load pulses on consecutive presses each reload; value changes on RawData without a press have no effect.
- databus = Extrn_Enable ? hold : 0, combinational from the register; Extrn_Enable affects only the bus, never loading.
- data2bit = hold[1:0] irrespective of Extrn_Enable.

## Timing
- Reset values: all FSMs IDLE, cnt=0, KeyLevel=0, KeyPulse=0, hold=0, DataValid=0, so databus=0 and data2bit=0.
- Reset asserted mid-count or while HELD: next cycle IDLE and outputs 0; a key still held after Reset must re-qualify the full DEBOUNCE_CYCLES before a pulse.
- Press latency: a key rising at sample cycle 0 and stable gives KeyLevel=1 and KeyPulse=1 registered at the end of sample cycle DEBOUNCE_CYCLES-1 (visible DEBOUNCE_CYCLES cycles after the first high sample), plus sync latency.
- Release latency: symmetric; KeyLevel falls DEBOUNCE_CYCLES cycles after the first stable low sample.
- A glitch of any length < DEBOUNCE_CYCLES produces no level change and no pulse.
- Simultaneous presses on different keys qualify independently; pulses may coincide.
- hold visible one cycle after KeyPulse[LATCH_KEY]; DataValid coincides with first visible new hold.

## Configuration
- INPUT_SYNC2_EN defined: RawKeys and RawData each pass through a two-flop synchronizer before sampling; all latencies grow by 2 cycles; sync flops reset to 0.
- Undefined: inputs sampled directly (board already synchronous, e.g. simulation); no added latency.

## Test plan
- DEBOUNCE_CYCLES=4, no sync macro: RawKeys[0] high and held 10 cycles → KeyLevel[0] rises and KeyPulse[0] high for exactly 1 cycle, 4 cycles after first high sample; no further pulse.
- Bounce: RawKeys[1] toggles 1,1,0,1,1,1,0 → no pulse, KeyLevel[1] stays 0.
- Load: RawData=10'h2A5, press key 1 → hold=10'h2A5, DataValid 1 cycle, data2bit=2'b01; Extrn_Enable=0 → databus=0; Extrn_Enable=1 → databus=10'h2A5.
- Release glitch: key 0 HELD, low for 3 cycles then high → KeyLevel[0] stays 1, no new pulse on return.
- Reset mid-operation: Reset during PRESS_CHK with cnt=2 and hold=10'h3FF → next cycle all outputs 0; held key needs 4 more stable cycles to pulse.
- INPUT_SYNC2_EN defined: repeat first scenario → pulse arrives 6 cycles after first raw high.

Source files
------------

// File: rtl/input_frontend.sv
// -----------------------------------------------------------------------------
// input_frontend
//
// Front-panel input stage: debounces NKEYS push-buttons, emits a clean level
// and a single-cycle press pulse per key, and captures the switch word into a
// holding register when the designated latch key is pressed. The holding
// register is presented on databus only while Extrn_Enable is high.
//
// Optional feature macro: INPUT_SYNC2_EN
//   defined   -> RawKeys and RawData pass through two-flop synchronizers
//                (two extra cycles of latency on every path, flops reset to 0)
//   undefined -> inputs are sampled directly (already synchronous source)
// -----------------------------------------------------------------------------
module input_frontend #(
  parameter int WIDTH           = 10,
  parameter int NKEYS           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LATCH_KEY       = 1
) (
  input  logic             CLK50M,
  input  logic             Reset,
  input  logic [WIDTH-1:0] RawData,
  input  logic [NKEYS-1:0] RawKeys,
  input  logic             Extrn_Enable,
  output logic [NKEYS-1:0] KeyLevel,
  output logic [NKEYS-1:0] KeyPulse,
  output logic [WIDTH-1:0] databus,
  output logic [1:0]       data2bit,
  output logic             DataValid
);

  // Counter is wide enough to hold DEBOUNCE_CYCLES, although it only ever
  // reaches DEBOUNCE_CYCLES-1 before the level change is accepted.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Debounce FSM encoding (shared by every key instance).
  localparam logic [1:0] ST_IDLE      = 2'd0;  // stable released, level 0
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;  // counting consecutive high samples
  localparam logic [1:0] ST_HELD      = 2'd2;  // stable pressed, level 1
  localparam logic [1:0] ST_REL_CHK   = 2'd3;  // counting consecutive low samples

  // Values actually seen by the debouncers and the holding register.
  logic [NKEYS-1:0] key_sample;
  logic [WIDTH-1:0] data_sample;

`ifdef INPUT_SYNC2_EN
  logic [NKEYS-1:0] key_meta_reg;
  logic [NKEYS-1:0] key_sync_reg;
  logic [WIDTH-1:0] data_meta_reg;
  logic [WIDTH-1:0] data_sync_reg;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge CLK50M) begin
    if (Reset) begin
      key_meta_reg  <= '0;
      key_sync_reg  <= '0;
      data_meta_reg <= '0;
      data_sync_reg <= '0;
    end else begin
      key_meta_reg  <= RawKeys;
      key_sync_reg  <= key_meta_reg;
      data_meta_reg <= RawData;
      data_sync_reg <= data_meta_reg;
    end
  end

  assign key_sample  = key_sync_reg;
  assign data_sample = data_sync_reg;
`else
  assign key_sample  = RawKeys;
  assign data_sample = RawData;
`endif

  // Per-key pulse vector gathered from the debouncer instances.
  logic [NKEYS-1:0] pulse_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic [1:0]    state_reg;
      logic [1:0]    state_next;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          level_reg;
      logic          level_next;
      logic          pulse_reg;
      logic          pulse_next;

      // Next-state logic: a level change is accepted only after
      // DEBOUNCE_CYCLES consecutive samples at the new value; any sample
      // back at the old value abandons the check.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        pulse_next = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (key_sample[gi]) begin
              state_next = ST_PRESS_CHK;
              cnt_next   = CNT_ONE;
            end else begin
              cnt_next   = '0;
            end
          end
          ST_PRESS_CHK: begin
            if (!key_sample[gi]) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = ST_HELD;
              cnt_next   = '0;
              level_next = 1'b1;
              pulse_next = 1'b1;
            end else begin
              cnt_next   = cnt_reg + CNT_ONE;
            end
          end
          ST_HELD: begin
            if (!key_sample[gi]) begin
              state_next = ST_REL_CHK;
              cnt_next   = CNT_ONE;
            end else begin
              cnt_next   = '0;
            end
          end
          ST_REL_CHK: begin
            if (key_sample[gi]) begin
              state_next = ST_HELD;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              // Release is accepted silently: pulses mark presses only.
              state_next = ST_IDLE;
              cnt_next   = '0;
              level_next = 1'b0;
            end else begin
              cnt_next   = cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            level_next = 1'b0;
          end
        endcase
      end

      // Debouncer state registers; reset forces the key to re-qualify.
      always_ff @(posedge CLK50M) begin
        if (Reset) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          pulse_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          level_reg <= level_next;
          pulse_reg <= pulse_next;
        end
      end

      assign KeyLevel[gi]  = level_reg;
      assign pulse_vec[gi] = pulse_reg;
    end
  endgenerate

  assign KeyPulse = pulse_vec;

  logic [WIDTH-1:0] hold_reg;
  logic             valid_reg;

  // Holding register: loads on the cycle the latch key's press pulse is
  // visible; DataValid marks the first cycle the new value is visible.
  always_ff @(posedge CLK50M) begin
    if (Reset) begin
      hold_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= pulse_vec[LATCH_KEY];
      if (pulse_vec[LATCH_KEY]) begin
        hold_reg <= data_sample;
      end
    end
  end

  // Bus is gated to zero rather than tri-stated; enable never affects loading.
  assign databus   = Extrn_Enable ? hold_reg : '0;
  assign data2bit  = hold_reg[1:0];
  assign DataValid = valid_reg;

endmodule

// File: tb/tb_input_frontend.sv
// -----------------------------------------------------------------------------
// tb_input_frontend
//
// Directed vector table (default build) or a synchronizer latency sequence
// (INPUT_SYNC2_EN build), followed by randomized traffic checked against a
// run-length reference model of the debounce and latch behaviour.
// -----------------------------------------------------------------------------
module tb_input_frontend;

  localparam int WIDTH = 10;
  localparam int NKEYS = 2;
  localparam int D     = 4;
  localparam int LK    = 1;
`ifdef INPUT_SYNC2_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             CLK50M;
  logic             Reset;
  logic [WIDTH-1:0] RawData;
  logic [NKEYS-1:0] RawKeys;
  logic             Extrn_Enable;
  logic [NKEYS-1:0] KeyLevel;
  logic [NKEYS-1:0] KeyPulse;
  logic [WIDTH-1:0] databus;
  logic [1:0]       data2bit;
  logic             DataValid;

  input_frontend #(
    .WIDTH(WIDTH), .NKEYS(NKEYS), .DEBOUNCE_CYCLES(D), .LATCH_KEY(LK)
  ) dut (
    .CLK50M(CLK50M), .Reset(Reset), .RawData(RawData), .RawKeys(RawKeys),
    .Extrn_Enable(Extrn_Enable), .KeyLevel(KeyLevel), .KeyPulse(KeyPulse),
    .databus(databus), .data2bit(data2bit), .DataValid(DataValid)
  );

  initial CLK50M = 1'b0;
  always #5 CLK50M = ~CLK50M;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Directed vector table: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic             rst;
    logic [NKEYS-1:0] keys;
    logic [WIDTH-1:0] data;
    logic             en;
    logic [NKEYS-1:0] lvl;
    logic [NKEYS-1:0] pls;
    logic [WIDTH-1:0] bus;
    logic [1:0]       d2;
    logic             val;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] k, input logic [9:0] d, input logic e,
                     input logic [1:0] l, input logic [1:0] p, input logic [9:0] b,
                     input logic [1:0] q, input logic v);
    vec_t x;
    x.rst = r; x.keys = k; x.data = d; x.en = e;
    x.lvl = l; x.pls = p; x.bus = b; x.d2 = q; x.val = v;
    vecs.push_back(x);
  endtask

  task automatic addn(input int n, input logic r, input logic [1:0] k, input logic [9:0] d,
                      input logic e, input logic [1:0] l, input logic [1:0] p,
                      input logic [9:0] b, input logic [1:0] q, input logic v);
    for (int i = 0; i < n; i++) add(r, k, d, e, l, p, b, q, v);
  endtask

  // Reference model: a key's level flips after D consecutive samples that
  // disagree with it; presses (0->1) raise a one-cycle pulse.
  logic [NKEYS-1:0] m_lvl, m_pls, m_k1, m_k2;
  logic [WIDTH-1:0] m_hold, m_d1, m_d2;
  logic             m_val;
  int               m_run [NKEYS];

  task automatic model_step(input logic r, input logic [1:0] k, input logic [9:0] d);
    logic [NKEYS-1:0] sk;
    logic [WIDTH-1:0] sd;
    if (r) begin
      m_lvl = '0; m_pls = '0; m_hold = '0; m_val = 1'b0;
      m_k1 = '0; m_k2 = '0; m_d1 = '0; m_d2 = '0;
      for (int i = 0; i < NKEYS; i++) m_run[i] = 0;
    end else begin
      sk = SYNC ? m_k2 : k;
      sd = SYNC ? m_d2 : d;
      m_k2 = m_k1; m_k1 = k; m_d2 = m_d1; m_d1 = d;
      m_val = m_pls[LK];
      if (m_pls[LK]) m_hold = sd;
      for (int i = 0; i < NKEYS; i++) begin
        m_pls[i] = 1'b0;
        if (sk[i] == m_lvl[i]) m_run[i] = 0;
        else m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          m_pls[i] = m_lvl[i];
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1; RawKeys = '0; RawData = '0; Extrn_Enable = 1'b0;

`ifndef INPUT_SYNC2_EN
    // reset
    addn(2, 1, 2'b00, 10'h000, 0, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    // key 0 held 10 cycles: pulse on the 4th sample only
    addn(3, 0, 2'b01, 10'h000, 0, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    add (   0, 2'b01, 10'h000, 0, 2'b01, 2'b01, 10'h000, 2'd0, 0);
    addn(6, 0, 2'b01, 10'h000, 0, 2'b01, 2'b00, 10'h000, 2'd0, 0);
    // release key 0
    addn(3, 0, 2'b00, 10'h000, 0, 2'b01, 2'b00, 10'h000, 2'd0, 0);
    add (   0, 2'b00, 10'h000, 0, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    // bounce on key 1: 1,1,0,1,1,1,0
    addn(2, 0, 2'b10, 10'h000, 0, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    add (   0, 2'b00, 10'h000, 0, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    addn(3, 0, 2'b10, 10'h000, 0, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    add (   0, 2'b00, 10'h000, 0, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    // load 2A5 via key 1 with bus disabled, then enable
    addn(3, 0, 2'b10, 10'h2A5, 0, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    add (   0, 2'b10, 10'h2A5, 0, 2'b10, 2'b10, 10'h000, 2'd0, 0);
    add (   0, 2'b10, 10'h2A5, 0, 2'b10, 2'b00, 10'h000, 2'd1, 1);
    add (   0, 2'b10, 10'h155, 1, 2'b10, 2'b00, 10'h2A5, 2'd1, 0);
    add (   0, 2'b10, 10'h155, 0, 2'b10, 2'b00, 10'h000, 2'd1, 0);
    // key 0 press, 3-cycle release glitch, return high: no new pulse
    addn(3, 0, 2'b11, 10'h155, 1, 2'b10, 2'b00, 10'h2A5, 2'd1, 0);
    add (   0, 2'b11, 10'h155, 1, 2'b11, 2'b01, 10'h2A5, 2'd1, 0);
    addn(3, 0, 2'b10, 10'h155, 1, 2'b11, 2'b00, 10'h2A5, 2'd1, 0);
    addn(3, 0, 2'b11, 10'h155, 1, 2'b11, 2'b00, 10'h2A5, 2'd1, 0);
    // release both
    addn(3, 0, 2'b00, 10'h155, 1, 2'b11, 2'b00, 10'h2A5, 2'd1, 0);
    add (   0, 2'b00, 10'h155, 1, 2'b00, 2'b00, 10'h2A5, 2'd1, 0);
    // load 3FF
    addn(3, 0, 2'b10, 10'h3FF, 1, 2'b00, 2'b00, 10'h2A5, 2'd1, 0);
    add (   0, 2'b10, 10'h3FF, 1, 2'b10, 2'b10, 10'h2A5, 2'd1, 0);
    add (   0, 2'b10, 10'h3FF, 1, 2'b10, 2'b00, 10'h3FF, 2'd3, 1);
    addn(3, 0, 2'b00, 10'h3FF, 1, 2'b10, 2'b00, 10'h3FF, 2'd3, 0);
    add (   0, 2'b00, 10'h3FF, 1, 2'b00, 2'b00, 10'h3FF, 2'd3, 0);
    // key 0 mid-count (cnt=2), then reset, then full re-qualification
    addn(2, 0, 2'b01, 10'h3FF, 1, 2'b00, 2'b00, 10'h3FF, 2'd3, 0);
    add (   1, 2'b01, 10'h3FF, 1, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    addn(3, 0, 2'b01, 10'h3FF, 1, 2'b00, 2'b00, 10'h000, 2'd0, 0);
    add (   0, 2'b01, 10'h3FF, 1, 2'b01, 2'b01, 10'h000, 2'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      Reset = vecs[i].rst; RawKeys = vecs[i].keys;
      RawData = vecs[i].data; Extrn_Enable = vecs[i].en;
      @(posedge CLK50M); #1;
      chk("vec_level", i, 32'(KeyLevel),  32'(vecs[i].lvl));
      chk("vec_pulse", i, 32'(KeyPulse),  32'(vecs[i].pls));
      chk("vec_bus",   i, 32'(databus),   32'(vecs[i].bus));
      chk("vec_d2",    i, 32'(data2bit),  32'(vecs[i].d2));
      chk("vec_valid", i, 32'(DataValid), 32'(vecs[i].val));
    end
`else
    // Synchronized build: pulse arrives 6 cycles after first raw high.
    Reset = 1'b1;
    repeat (2) @(posedge CLK50M);
    #1;
    Reset = 1'b0; RawKeys = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      @(posedge CLK50M); #1;
      chk("sync_pulse", i, 32'(KeyPulse[0]), (i == 6) ? 32'd1 : 32'd0);
      chk("sync_level", i, 32'(KeyLevel[0]), (i >= 6) ? 32'd1 : 32'd0);
    end
`endif

    // Randomized traffic against the reference model.
    Reset = 1'b1; RawKeys = '0; RawData = '0; Extrn_Enable = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c < 2) Reset = 1'b1;
      else Reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NKEYS; k++)
        if ($urandom_range(0, 9) == 0) RawKeys[k] = ~RawKeys[k];
      RawData = WIDTH'($urandom);
      Extrn_Enable = $urandom_range(0, 1) == 1;
      @(posedge CLK50M);
      model_step(Reset, RawKeys, RawData);
      #1;
      chk("rnd_level", c, 32'(KeyLevel),  32'(m_lvl));
      chk("rnd_pulse", c, 32'(KeyPulse),  32'(m_pls));
      chk("rnd_bus",   c, 32'(databus),   Extrn_Enable ? 32'(m_hold) : 32'd0);
      chk("rnd_d2",    c, 32'(data2bit),  32'(m_hold[1:0]));
      chk("rnd_valid", c, 32'(DataValid), 32'(m_val));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
